// File: rtl/i2c_master_engine.sv
// i2c_master_engine
// Byte-level I2C master engine. Takes single-cycle command pulses from a
// register front end and drives open-drain SDA/SCL pads through a bit/byte
// state machine timed by an internal quarter-period tick divider.
//
// Handshake: a command pulse (cmd_*) is taken only on a clock edge where
// busy = 0; pulses seen while busy = 1 are dropped. Each taken command ends
// either with a one-cycle done pulse or, for a write that loses arbitration,
// a one-cycle arb_lost pulse. busy falls in the same cycle as either pulse.
//
// Optional feature: define I2C_CLK_STRETCH_EN to let a slave stretch SCL.
// In p1 of every slot the tick counter then holds at reload until the
// synchronised scl_i reads high. Without the macro scl_i only feeds the
// debug output.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   clk_div            quarter SCL period minus 1, latched when a command is taken
//   txdata / rxdata    byte to send (latched on write) / last byte received
//   cmd_start, cmd_stop, cmd_write, cmd_read_ack, cmd_read_nack
//                      command pulses, priority in that order
//   busy, ack, done, arb_lost
//                      status: in progress, slave ACKed last write,
//                      completion pulse, arbitration-loss pulse
//   sda_i, scl_i       pad inputs
//   sda_o, scl_o       pad drives (0 = pull low, 1 = release)
//   dbg_state          current FSM state
//   dbg_lines          {synchronised scl, synchronised sda}
module i2c_master_engine #(
   parameter int DIV_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [DIV_W-1:0] clk_div,
   input  logic [7:0]       txdata,
   output logic [7:0]       rxdata,
   input  logic             cmd_start,
   input  logic             cmd_stop,
   input  logic             cmd_write,
   input  logic             cmd_read_ack,
   input  logic             cmd_read_nack,
   output logic             busy,
   output logic             ack,
   output logic             done,
   output logic             arb_lost,
   input  logic             sda_i,
   input  logic             scl_i,
   output logic             sda_o,
   output logic             scl_o,
   output logic [2:0]       dbg_state,
   output logic [1:0]       dbg_lines
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_STOP  = 3'd2,
      S_WRITE = 3'd3,
      S_READ  = 3'd4
   } state_t;

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] sda_sync, scl_sync;
   logic                   sda_s, scl_s;
   logic [DIV_W-1:0]       div_q, cnt;
   logic [1:0]             ph;        // phase within the current bit slot
   logic [3:0]             slot;      // 0..7 data slots, 8 = ACK slot
   logic [7:0]             sh;        // tx shift (write) / rx shift (read)
   logic                   nack_q;
   logic                   accept, tick, stretch_hold, last_slot, finish, arb;
   logic                   next_bit, sda_nxt, scl_nxt;

   // Pad input synchronisers; idle bus reads high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sda_sync <= '1;
         scl_sync <= '1;
      end else begin
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      end
   end
   assign sda_s = sda_sync[SYNC_STAGES-1];
   assign scl_s = scl_sync[SYNC_STAGES-1];

`ifdef I2C_CLK_STRETCH_EN
   // SCL was released on entry to p1; wait until the bus actually reads high.
   assign stretch_hold = (ph == 2'd1) && !scl_s;
`else
   assign stretch_hold = 1'b0;
`endif

   assign accept    = (state == S_IDLE) &&
                      (cmd_start || cmd_stop || cmd_write || cmd_read_ack || cmd_read_nack);
   assign tick      = (state != S_IDLE) && (cnt == '0) && !stretch_hold;
   assign last_slot = !((state == S_WRITE) || (state == S_READ)) || (slot == 4'd8);
   assign finish    = tick && (ph == 2'd3) && last_slot;
   // Sampling point of a write data slot: we released SDA but the bus is low.
   assign arb       = (state == S_WRITE) && tick && (ph == 2'd1) && (slot != 4'd8) &&
                      sda_o && !sda_s;

   assign busy      = (state != S_IDLE);
   assign dbg_state = state;
   assign dbg_lines = {scl_s, sda_s};

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // FSM next state
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if      (cmd_start)                     state_nxt = S_START;
            else if (cmd_stop)                      state_nxt = S_STOP;
            else if (cmd_write)                     state_nxt = S_WRITE;
            else if (cmd_read_ack || cmd_read_nack) state_nxt = S_READ;
         end
         default: if (arb || finish) state_nxt = S_IDLE;
      endcase
   end

   // SDA level for p0 of the following slot.
   always_comb begin
      next_bit = 1'b1;
      if (state == S_WRITE)     next_bit = (slot == 4'd7) ? 1'b1 : sh[6];
      else if (state == S_READ) next_bit = (slot == 4'd7) ? nack_q : 1'b1;
   end

   // FSM outputs: line levels for the next cycle (registered below).
   always_comb begin
      sda_nxt = sda_o;
      scl_nxt = scl_o;
      if (state == S_IDLE) begin
         // p0 of the first slot is applied on the accept edge itself.
         if (cmd_start) begin
            sda_nxt = 1'b1;
         end else if (cmd_stop) begin
            sda_nxt = 1'b0;
            scl_nxt = 1'b0;
         end else if (cmd_write) begin
            sda_nxt = txdata[7];
            scl_nxt = 1'b0;
         end else if (cmd_read_ack || cmd_read_nack) begin
            sda_nxt = 1'b1;
            scl_nxt = 1'b0;
         end
      end else if (arb) begin
         sda_nxt = 1'b1;
         scl_nxt = 1'b1;
      end else if (tick) begin
         case (ph)
            2'd0: scl_nxt = 1'b1;
            2'd1: begin
               if (state == S_START)     sda_nxt = 1'b0;
               else if (state == S_STOP) sda_nxt = 1'b1;
            end
            2'd2: if (state != S_STOP) scl_nxt = 1'b0;
            default: begin
               if (!last_slot) begin
                  scl_nxt = 1'b0;
                  sda_nxt = next_bit;
               end
            end
         endcase
      end
   end

   // Datapath: lines, divider, slot/phase counters, shifter, status.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sda_o    <= 1'b1;
         scl_o    <= 1'b1;
         done     <= 1'b0;
         arb_lost <= 1'b0;
         ack      <= 1'b0;
         rxdata   <= 8'h00;
         div_q    <= '0;
         cnt      <= '0;
         ph       <= 2'd0;
         slot     <= 4'd0;
         sh       <= 8'h00;
         nack_q   <= 1'b0;
      end else begin
         sda_o    <= sda_nxt;
         scl_o    <= scl_nxt;
         done     <= finish;
         arb_lost <= arb;
         if (accept) begin
            div_q  <= clk_div;
            cnt    <= clk_div;
            ph     <= 2'd0;
            slot   <= 4'd0;
            nack_q <= !cmd_read_ack;
            if (state_nxt == S_WRITE) sh <= txdata;
         end else if (state != S_IDLE) begin
            if (tick || stretch_hold) cnt <= div_q;
            else                      cnt <= cnt - DIV_W'(1);
            if (tick) begin
               ph <= ph + 2'd1;
               if (ph == 2'd1) begin
                  if (state == S_READ && slot != 4'd8)  sh  <= {sh[6:0], sda_s};
                  if (state == S_WRITE && slot == 4'd8) ack <= !sda_s;
               end
               if (ph == 2'd3) begin
                  slot <= slot + 4'd1;
                  if (state == S_WRITE)          sh     <= {sh[6:0], 1'b0};
                  if (state == S_READ && finish) rxdata <= sh;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_i2c_master_engine.sv
`timescale 1ns/1ps
module tb_i2c_master_engine;

   localparam int DIV_W = 16;
   localparam int SYNC  = 2;
`ifdef I2C_CLK_STRETCH_EN
   localparam int STR     = SYNC;  // extra cycles per slot from SCL read-back
   localparam bit STRETCH = 1'b1;
`else
   localparam int STR     = 0;
   localparam bit STRETCH = 1'b0;
`endif

   localparam logic [4:0] C_START = 5'b10000;
   localparam logic [4:0] C_STOP  = 5'b01000;
   localparam logic [4:0] C_WRITE = 5'b00100;
   localparam logic [4:0] C_RACK  = 5'b00010;
   localparam logic [4:0] C_RNACK = 5'b00001;

   // clock / reset
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic [DIV_W-1:0] clk_div = '0;
   logic [7:0] txdata = 8'h00, rxdata;
   logic cmd_start = 0, cmd_stop = 0, cmd_write = 0, cmd_read_ack = 0, cmd_read_nack = 0;
   logic busy, ack, done, arb_lost, sda_i, scl_i, sda_o, scl_o;
   logic [2:0] dbg_state;
   logic [1:0] dbg_lines;
   logic slave_sda = 1'b1;
   logic scl_hold  = 1'b0;

   // open-drain bus: wired-AND of master and slave
   assign sda_i = sda_o & slave_sda;
   assign scl_i = scl_o & ~scl_hold;

   i2c_master_engine #(.DIV_W(DIV_W), .SYNC_STAGES(SYNC)) dut (
      .clk(clk), .reset_n(reset_n), .clk_div(clk_div), .txdata(txdata), .rxdata(rxdata),
      .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_write(cmd_write),
      .cmd_read_ack(cmd_read_ack), .cmd_read_nack(cmd_read_nack),
      .busy(busy), .ack(ack), .done(done), .arb_lost(arb_lost),
      .sda_i(sda_i), .scl_i(scl_i), .sda_o(sda_o), .scl_o(scl_o),
      .dbg_state(dbg_state), .dbg_lines(dbg_lines)
   );

   int n_cmp = 0;
   int n_err = 0;

   // reference state of the bus / engine as the bench expects it
   logic [7:0] exp_rx   = 8'h00;
   logic       exp_ack  = 1'b0;
   logic       line_scl = 1'b1;
   logic [7:0] exp_q[$];

   // results of one command
   int         r_lat, r_fall_hi, r_rise_hi;
   bit         r_done, r_arb, r_busy_bad;
   logic [8:0] r_p1;

   // Reference for a byte transfer. slv[k] = level the slave puts on SDA in slot k.
   function automatic void model_byte(input bit is_wr, input bit nack, input logic [7:0] tx,
                                      input logic [8:0] slv, input int d,
                                      output int lat, output bit arbx, output int arb_slot,
                                      output logic [8:0] p1, output logic [7:0] rx,
                                      output logic ackx);
      int q;
      q = 4 * (d + 1);
      arbx = 0; arb_slot = 9; p1 = '1; rx = 8'h00;
      for (int k = 0; k < 9; k++) begin
         p1[k] = is_wr ? ((k < 8) ? tx[7-k] : 1'b1) : ((k < 8) ? 1'b1 : nack);
         if (!arbx && is_wr && k < 8 && p1[k] && !slv[k]) begin
            arbx = 1; arb_slot = k;
         end
      end
      for (int k = 0; k < 8; k++) rx[7-k] = slv[k];
      ackx = ~slv[8];
      if (arbx) lat = arb_slot * q + 2 * (d + 1) + (arb_slot + 1) * STR;
      else      lat = 9 * q + 9 * STR;
   endfunction

   // driver + bus monitor + slave for one command
   task automatic run_cmd(input logic [4:0] cmd, input logic [7:0] tx, input logic [8:0] slv,
                          input int d, input bit poke, input int stretch, input int budget);
      int falls, rises, rise0;
      logic ps, pc;
      @(negedge clk);
      clk_div = DIV_W'(d);
      txdata  = tx;
      {cmd_start, cmd_stop, cmd_write, cmd_read_ack, cmd_read_nack} = cmd;
      ps = sda_o; pc = scl_o;
      @(posedge clk);
      #1;
      {cmd_start, cmd_stop, cmd_write, cmd_read_ack, cmd_read_nack} = 5'b0;
      falls = 0; rises = 0; rise0 = -1;
      r_lat = 0; r_done = 0; r_arb = 0; r_busy_bad = 0; r_p1 = '1;
      r_fall_hi = -1; r_rise_hi = -1;
      slave_sda = slv[0];
      if (stretch > 0) scl_hold = 1'b1;
      while (r_lat < budget && !r_done && !r_arb) begin
         @(posedge clk);
         r_lat++;
         @(negedge clk);
         if (done)     r_done = 1;
         if (arb_lost) r_arb  = 1;
         if (!(r_done || r_arb) && busy !== 1'b1) r_busy_bad = 1;
         if ((r_done || r_arb) && busy !== 1'b0)  r_busy_bad = 1;
         if (!pc && scl_o) begin
            if (rises < 9) r_p1[rises] = sda_o;
            if (rise0 < 0) rise0 = r_lat;
            rises++;
         end
         if (pc && !scl_o) begin
            falls++;
            slave_sda = (falls < 9) ? slv[falls] : 1'b1;
         end
         if (ps && !sda_o && pc && scl_o) r_fall_hi = r_lat;
         if (!ps && sda_o && pc && scl_o) r_rise_hi = r_lat;
         if (stretch > 0 && rise0 >= 0 && r_lat == rise0 + stretch) scl_hold = 1'b0;
         if (poke && r_lat == 5) cmd_write = 1'b1;
         if (poke && r_lat == 6) cmd_write = 1'b0;
         ps = sda_o; pc = scl_o;
      end
      slave_sda = 1'b1;
      scl_hold  = 1'b0;
      cmd_write = 1'b0;
   endtask

   task automatic do_start(input int d);
      int exp_lat;
      exp_lat = 4 * (d + 1) + (line_scl ? 0 : STR);
      run_cmd(C_START, 8'h00, 9'h1FF, d, 0, 0, 400);
      n_cmp++;
      if (r_lat !== exp_lat || !r_done) begin
         n_err++;
         $display("FAIL start_latency: got %0d done=%0d, want %0d", r_lat, r_done, exp_lat);
      end
      line_scl = 1'b0;
   endtask

   task automatic test_reset();
      cmd_start = 1; cmd_write = 1; cmd_stop = 1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({sda_o, scl_o, busy, done, arb_lost, ack} !== 6'b110000 || rxdata !== 8'h00) begin
         n_err++;
         $display("FAIL reset_outputs: got sda=%b scl=%b busy=%b done=%b arb=%b ack=%b rx=%h, want 1 1 0 0 0 0 00",
                  sda_o, scl_o, busy, done, arb_lost, ack, rxdata);
      end
      cmd_start = 0; cmd_write = 0; cmd_stop = 0;
      reset_n = 1;
      repeat (3) begin
         @(negedge clk);
         n_cmp++;
         if (busy !== 1'b0 || done !== 1'b0 || sda_o !== 1'b1 || scl_o !== 1'b1) begin
            n_err++;
            $display("FAIL reset_idle: got busy=%b done=%b sda=%b scl=%b, want 0 0 1 1", busy, done, sda_o, scl_o);
         end
      end
   endtask

   task automatic test_start();
      do_start(3);
      n_cmp++;
      if (r_fall_hi !== 8) begin
         n_err++;
         $display("FAIL start_sda_fall: got cycle %0d, want 8", r_fall_hi);
      end
      n_cmp++;
      if (scl_o !== 1'b0 || sda_o !== 1'b0 || r_busy_bad) begin
         n_err++;
         $display("FAIL start_end_lines: got scl=%b sda=%b busy_bad=%0d, want 0 0 0", scl_o, sda_o, r_busy_bad);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin
         n_err++;
         $display("FAIL done_width: got done=%b one cycle later, want 0", done);
      end
   endtask

   task automatic test_write();
      int el, as; bit ea; logic [8:0] ep; logic [7:0] erx; logic eack;
      model_byte(1, 0, 8'hA5, 9'h0FF, 3, el, ea, as, ep, erx, eack);
      run_cmd(C_WRITE, 8'hA5, 9'h0FF, 3, 1, 0, 400);
      n_cmp++;
      if (r_lat !== el || !r_done || r_arb) begin
         n_err++;
         $display("FAIL write_latency: got %0d done=%0d arb=%0d, want %0d", r_lat, r_done, r_arb, el);
      end
      n_cmp++;
      if (r_p1 !== ep) begin
         n_err++;
         $display("FAIL write_bits: got %b, want %b", r_p1, ep);
      end
      exp_ack = eack;
      n_cmp++;
      if (ack !== exp_ack || rxdata !== exp_rx) begin
         n_err++;
         $display("FAIL write_ack: got ack=%b rx=%h, want ack=%b rx=%h", ack, rxdata, exp_ack, exp_rx);
      end
      repeat (20) begin
         @(negedge clk);
         if (busy !== 1'b0 || done !== 1'b0) r_busy_bad = 1;
      end
      n_cmp++;
      if (r_busy_bad) begin
         n_err++;
         $display("FAIL write_busy_ignore: got busy profile bad=1, want 0");
      end
   endtask

   task automatic test_read_nack();
      int el, as; bit ea; logic [8:0] ep, slv; logic [7:0] erx; logic eack;
      for (int k = 0; k < 8; k++) slv[k] = 8'h3C >> (7 - k);
      slv[8] = 1'b1;
      model_byte(0, 1, 8'h00, slv, 3, el, ea, as, ep, erx, eack);
      run_cmd(C_RNACK, 8'h00, slv, 3, 0, 0, 400);
      exp_rx = erx;
      n_cmp++;
      if (r_lat !== el || !r_done) begin
         n_err++;
         $display("FAIL read_latency: got %0d done=%0d, want %0d", r_lat, r_done, el);
      end
      n_cmp++;
      if (rxdata !== exp_rx || exp_rx !== 8'h3C) begin
         n_err++;
         $display("FAIL read_data: got %h, want %h", rxdata, exp_rx);
      end
      n_cmp++;
      if (r_p1 !== ep) begin
         n_err++;
         $display("FAIL read_sda_released: got %b, want %b", r_p1, ep);
      end
   endtask

   task automatic test_arbitration();
      int el, as; bit ea; logic [8:0] ep; logic [7:0] erx; logic eack;
      model_byte(1, 0, 8'hFF, 9'h1F7, 3, el, ea, as, ep, erx, eack);
      run_cmd(C_WRITE, 8'hFF, 9'h1F7, 3, 1, 0, 400);
      n_cmp++;
      if (!r_arb || r_done || r_lat !== el) begin
         n_err++;
         $display("FAIL arb_pulse: got arb=%0d done=%0d at %0d, want arb=1 done=0 at %0d", r_arb, r_done, r_lat, el);
      end
      n_cmp++;
      if (sda_o !== 1'b1 || scl_o !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL arb_release: got sda=%b scl=%b busy=%b, want 1 1 0", sda_o, scl_o, busy);
      end
      r_busy_bad = 0;
      repeat (30) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0 || arb_lost !== 1'b0) r_busy_bad = 1;
      end
      n_cmp++;
      if (r_busy_bad || ack !== exp_ack) begin
         n_err++;
         $display("FAIL arb_quiet: got late activity=%0d ack=%b, want 0 ack=%b", r_busy_bad, ack, exp_ack);
      end
      line_scl = 1'b1;
   endtask

   task automatic test_priority();
      logic [7:0] tx;
      logic [8:0] ep;
      // all pulses together: START wins (bus idle-high after arbitration loss)
      run_cmd(5'b11111, 8'h00, 9'h1FF, 1, 0, 0, 400);
      n_cmp++;
      if (r_lat !== 8 || r_fall_hi !== 4 || !r_done) begin
         n_err++;
         $display("FAIL prio_start: got lat=%0d fall=%0d, want 8 4", r_lat, r_fall_hi);
      end
      line_scl = 1'b0;
      // write beats both reads
      tx = 8'($urandom);
      for (int k = 0; k < 8; k++) ep[k] = tx[7-k];
      ep[8] = 1'b1;
      run_cmd(C_WRITE | C_RACK | C_RNACK, tx, 9'h1FF, 1, 0, 0, 400);
      exp_ack = 1'b0;
      n_cmp++;
      if (r_p1 !== ep || rxdata !== exp_rx || ack !== exp_ack || r_lat !== 72 + 9 * STR) begin
         n_err++;
         $display("FAIL prio_write: got bits=%b rx=%h ack=%b lat=%0d, want %b %h %b %0d",
                  r_p1, rxdata, ack, r_lat, ep, exp_rx, exp_ack, 72 + 9 * STR);
      end
      // stop beats write/read
      run_cmd(C_STOP | C_WRITE | C_RACK, 8'h00, 9'h1FF, 1, 0, 0, 400);
      n_cmp++;
      if (r_lat !== 8 + STR || r_rise_hi !== 4 + STR || sda_o !== 1'b1 || scl_o !== 1'b1) begin
         n_err++;
         $display("FAIL prio_stop: got lat=%0d rise=%0d sda=%b scl=%b, want %0d %0d 1 1",
                  r_lat, r_rise_hi, sda_o, scl_o, 8 + STR, 4 + STR);
      end
      line_scl = 1'b1;
   endtask

   task automatic test_random();
      int d, el, as, nb; bit ea, is_wr, nack, arbed; logic [8:0] ep, slv, mask;
      logic [7:0] tx, erx; logic eack;
      for (int t = 0; t < 6; t++) begin
         d = $urandom_range(0, 3);
         do_start(d);
         nb = $urandom_range(1, 3);
         arbed = 0;
         for (int b = 0; b < nb && !arbed; b++) begin
            is_wr = 1'($urandom_range(0, 1));
            nack  = 1'($urandom_range(0, 1));
            tx    = 8'($urandom);
            if (is_wr) slv[7:0] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            else       slv[7:0] = 8'($urandom);
            slv[8] = is_wr ? 1'($urandom_range(0, 1)) : 1'b1;
            model_byte(is_wr, nack, tx, slv, d, el, ea, as, ep, erx, eack);
            run_cmd(is_wr ? C_WRITE : (nack ? C_RNACK : C_RACK), tx, slv, d, 0, 0, 400);
            mask = '1;
            if (ea) for (int k = 0; k < 9; k++) if (k > as) mask[k] = 1'b0;
            n_cmp++;
            if (r_lat !== el || r_arb !== ea || r_done === ea || (r_p1 & mask) !== (ep & mask)) begin
               n_err++;
               $display("FAIL rand_byte wr=%0d d=%0d: got lat=%0d arb=%0d bits=%b, want %0d %0d %b",
                        is_wr, d, r_lat, r_arb, r_p1 & mask, el, ea, ep & mask);
            end
            if (ea) begin
               arbed = 1;
               line_scl = 1'b1;
               repeat (4) @(negedge clk);
            end else if (is_wr) begin
               exp_ack = eack;
            end else begin
               exp_rx = erx;
               exp_q.push_back(erx);
            end
            n_cmp++;
            if (ack !== exp_ack) begin
               n_err++;
               $display("FAIL rand_ack: got %b, want %b", ack, exp_ack);
            end
            if (!is_wr && !ea) begin
               n_cmp++;
               if (rxdata !== exp_q.pop_front()) begin
                  n_err++;
                  $display("FAIL rand_rx: got %h, want %h", rxdata, erx);
               end
            end
         end
         if (!arbed) begin
            run_cmd(C_STOP, 8'h00, 9'h1FF, d, 0, 0, 400);
            n_cmp++;
            if (r_lat !== 4 * (d + 1) + STR || sda_o !== 1'b1 || scl_o !== 1'b1) begin
               n_err++;
               $display("FAIL rand_stop: got lat=%0d sda=%b scl=%b, want %0d 1 1",
                        r_lat, sda_o, scl_o, 4 * (d + 1) + STR);
            end
            line_scl = 1'b1;
         end
      end
   endtask

   task automatic test_stretch();
      int exp_lat;
      do_start(3);
      exp_lat = 144 + (STRETCH ? 9 * STR + 50 : 0);
      run_cmd(C_WRITE, 8'h00, 9'h000, 3, 0, 50, 600);
      exp_ack = 1'b1;
      n_cmp++;
      if (r_lat !== exp_lat || !r_done || ack !== exp_ack) begin
         n_err++;
         $display("FAIL stretch_latency: got %0d done=%0d ack=%b, want %0d 1 1", r_lat, r_done, ack, exp_lat);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      clk_div = 16'd3; txdata = 8'h00;
      cmd_write = 1;
      @(negedge clk);
      cmd_write = 0;
      repeat (20) @(negedge clk);
      #2 reset_n = 0;
      #1;
      n_cmp++;
      if (sda_o !== 1'b1 || scl_o !== 1'b1 || busy !== 1'b0 || ack !== 1'b0 || rxdata !== 8'h00) begin
         n_err++;
         $display("FAIL reset_mid: got sda=%b scl=%b busy=%b ack=%b rx=%h, want 1 1 0 0 00",
                  sda_o, scl_o, busy, ack, rxdata);
      end
      @(negedge clk);
      reset_n = 1;
      exp_ack = 0; exp_rx = 0; line_scl = 1;
   endtask

   initial begin
      test_reset();
      test_start();
      test_write();
      test_read_nack();
      test_arbitration();
      test_priority();
      test_random();
      test_stretch();
      test_reset_mid();
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/i2c_master_engine.md
Name: i2c_master_engine

Overview:
- Parametrised byte-level I2C master engine; next generation of the team's I2C core.
- Adds on top of the integrated clock divider: a complete bit/byte state machine, input synchronisers, ACK capture, arbitration-loss detection, and optional SCL clock stretching.
- Sits between a register-file/command front end (single-cycle command pulses) and open-drain pad cells (sda/scl in/out).

Parameters:
- DIV_W, 16: width of the clk_div input and the quarter-period tick counter.
- SYNC_STAGES, 2: flops in the sda_i/scl_i synchronisers (minimum 2).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- clk_div  input  DIV_W  quarter-SCL period minus 1, in clk cycles; latched on command accept.
- txdata  input  8  byte to transmit, MSB first; latched on cmd_write accept.
- rxdata  output  8  last received byte.
- cmd_start  input  1  pulse: (repeated) START.
- cmd_stop  input  1  pulse: STOP.
- cmd_write  input  1  pulse: write txdata, then sample ACK.
- cmd_read_ack  input  1  pulse: read byte, then drive ACK.
- cmd_read_nack  input  1  pulse: read byte, then drive NACK.
- busy  output  1  command in progress.
- ack  output  1  1 = slave ACKed last write (SDA low in ACK slot).
- done  output  1  one-cycle pulse when a command completes.
- arb_lost  output  1  one-cycle pulse on arbitration loss.
- sda_i  input  1  SDA pad input.
- scl_i  input  1  SCL pad input.
- sda_o  output  1  0 = pull SDA low, 1 = release.
- scl_o  output  1  0 = pull SCL low, 1 = release.

Behaviour:
- Reset (async):
  - sda_o = 1, scl_o = 1; busy, done, arb_lost, ack = 0; rxdata = 0; state IDLE.
  - Reset mid-command releases both lines immediately.
- Command accept:
  - Commands are accepted only in IDLE (busy = 0); pulses arriving while busy are ignored.
  - Priority when several pulses coincide: start > stop > write > read_ack > read_nack.
  - busy rises the cycle after accept.
- Tick generation:
  - Tick counter reloads at accept and fires every (clk_div + 1) cycles; clk_div = 0 gives a tick every cycle.
  - One bit slot = 4 ticks (phases 0..3); SCL period = 4·(clk_div + 1) cycles.
- Slot sequences (lines named by their driven value):
  - START: p0 SDA = 1 (SCL unchanged), p1 SCL = 1, p2 SDA = 0, p3 SCL = 0.
  - STOP: p0 SDA = 0 with SCL = 0, p1 SCL = 1, p2 SDA = 1, p3 hold.
  - Data/ACK slot: p0 set SDA with SCL = 0, p1 SCL = 1, p2 sample synchronised SDA, p3 SCL = 0.
- Write:
  - 8 data slots MSB first, then an ACK slot with SDA released.
  - ack = NOT (sample in ACK slot); updated at the ACK-slot p2.
- Read:
  - 8 slots with SDA released; samples shift into rxdata LSB-first shift, MSB received first.
  - 9th slot drives SDA = 0 (read_ack) or SDA = 1 (read_nack).
  - rxdata updates when the command completes.
- Completion:
  - After the final p3 tick: done pulses one cycle, busy falls in the same cycle, state returns to IDLE.
  - Latency from accept to done is exactly slots·4·(clk_div + 1) cycles: START/STOP = 1 slot, WRITE/READ = 9 slots.
- Arbitration:
  - During WRITE data slots only: if sda_o = 1 and the synchronised SDA samples 0 at p2, arb_lost pulses and both lines release.
  - The engine goes to IDLE without done and without driving the remaining bits.
- Synchronisers: sda_i and scl_i pass through SYNC_STAGES flops, reset to 1.
- Between commands, the lines hold their last driven values, so SCL stays low after a byte.

Optional Feature:
- Macro: I2C_CLK_STRETCH_EN.
- Defined: in p1 of every slot, after releasing SCL, the tick counter holds at reload until synchronised scl_i = 1; counting then resumes. Total latency grows by the stretch duration plus sync delay.
- Undefined: scl_i is unused and latency is exactly as specified above.

Test Plan:
- Reset with cmd pulses active -> sda_o = 1, scl_o = 1, busy = 0, done = 0 until the first accepted command.
- clk_div = 3, cmd_start -> SDA falls while SCL is high at tick 2; done 16 cycles after accept; scl_o = 0 afterwards.
- clk_div = 3, txdata = 0xA5, slave ties SDA low in ACK slot -> SDA bits 1,0,1,0,0,1,0,1 at p1; done after 144 cycles; ack = 1.
- cmd_read_nack, slave drives 0x3C -> rxdata = 0x3C at done; SDA released in slot 9.
- cmd_write 0xFF, external SDA forced low in bit 3 -> arb_lost pulse; sda_o = scl_o = 1; no done; busy = 0; cmd_write during busy ignored.
- With I2C_CLK_STRETCH_EN, hold scl_i low 50 cycles in the first write slot -> done at 144 + 50 + sync delay cycles; without the macro, done at 144.
